// File: rtl/idu_stage_pkg.sv
// Shared decode definitions: opcodes, execute/LSU control encodings and the
// decoded-instruction bundle passed from idu_dec to the stage register.
package idu_stage_pkg;

  localparam int EXU_SEL_WIDTH = 3;
  localparam int EXU_OPT_WIDTH = 5;
  localparam int LSU_OPT_WIDTH = 4;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] INS_EBREAK = 32'h00100073;

  // {func3,0}=load, {func3,1}=store; 4'b1111 is never a legal access code.
  localparam logic [LSU_OPT_WIDTH-1:0] LSU_NOP = 4'b1111;

  typedef enum logic [EXU_OPT_WIDTH-1:0] {
    EXU_ADD, EXU_SUB, EXU_SLL, EXU_SLT, EXU_SLTU, EXU_XOR, EXU_SRL, EXU_SRA,
    EXU_OR, EXU_AND,
    EXU_MUL, EXU_MULH, EXU_MULHSU, EXU_MULHU, EXU_DIV, EXU_DIVU, EXU_REM, EXU_REMU,
    EXU_BEQ, EXU_BNE, EXU_BLT, EXU_BGE, EXU_BLTU, EXU_BGEU
  } exu_opt_e;

  typedef enum logic [EXU_SEL_WIDTH-1:0] {
    SEL_RS1_RS2, SEL_RS1_IMM, SEL_PC_IMM, SEL_ZERO_IMM, SEL_PC_4
  } exu_sel_e;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_HALT} state_e;

  typedef struct packed {
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic                     rdwen;
    exu_sel_e                 src_sel;
    exu_opt_e                 exu_opt;
    logic [LSU_OPT_WIDTH-1:0] lsu_opt;
    logic                     word;
    logic                     brch;
    logic                     jal;
    logic                     jalr;
    logic                     ebreak;
    logic                     illegal;
  } dec_t;

  function automatic exu_opt_e alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? EXU_SUB : EXU_ADD;
      3'b001:  return EXU_SLL;
      3'b010:  return EXU_SLT;
      3'b011:  return EXU_SLTU;
      3'b100:  return EXU_XOR;
      3'b101:  return alt ? EXU_SRA : EXU_SRL;
      3'b110:  return EXU_OR;
      default: return EXU_AND;
    endcase
  endfunction

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32/RV64 (+M) instruction decoder: instruction word in,
// decoded control bundle and sign-extended immediate out.
module idu_dec
  import idu_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 1
) (
  input  logic [31:0]     ins_i,
  output dec_t            dec_o,
  output logic [XLEN-1:0] imm_o
);

  localparam bit RV64 = (XLEN == 64);
  localparam bit HAS_M = (EN_M != 0);

  logic [6:0]        opc;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic signed [31:0] imm32;
  logic              ill;
  logic              wen;
  dec_t              d;

  assign opc = ins_i[6:0];
  assign f3  = ins_i[14:12];
  assign f7  = ins_i[31:25];

  always_comb begin
    d         = '0;
    d.rs1     = ins_i[19:15];
    d.rs2     = ins_i[24:20];
    d.rd      = ins_i[11:7];
    d.src_sel = SEL_RS1_RS2;
    d.exu_opt = EXU_ADD;
    d.lsu_opt = LSU_NOP;
    imm32     = '0;
    ill       = 1'b0;
    wen       = 1'b0;
    case (opc)
      OPC_LUI: begin
        imm32 = {ins_i[31:12], 12'b0};
        d.src_sel = SEL_ZERO_IMM;
        wen = 1'b1;
      end
      OPC_AUIPC: begin
        imm32 = {ins_i[31:12], 12'b0};
        d.src_sel = SEL_PC_IMM;
        wen = 1'b1;
      end
      OPC_JAL: begin
        imm32 = {{12{ins_i[31]}}, ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
        d.src_sel = SEL_PC_4;
        d.jal = 1'b1;
        wen = 1'b1;
      end
      OPC_JALR: begin
        imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
        d.src_sel = SEL_PC_4;
        d.jalr = 1'b1;
        wen = 1'b1;
        ill = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        imm32 = {{20{ins_i[31]}}, ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
        d.brch = 1'b1;
        case (f3)
          3'b000:  d.exu_opt = EXU_BEQ;
          3'b001:  d.exu_opt = EXU_BNE;
          3'b100:  d.exu_opt = EXU_BLT;
          3'b101:  d.exu_opt = EXU_BGE;
          3'b110:  d.exu_opt = EXU_BLTU;
          3'b111:  d.exu_opt = EXU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
        d.src_sel = SEL_RS1_IMM;
        d.lsu_opt = {f3, 1'b0};
        wen = 1'b1;
        case (f3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ill = 1'b0;
          3'b011, 3'b110:                         ill = !RV64;
          default:                                ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        imm32 = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
        d.src_sel = SEL_RS1_IMM;
        d.lsu_opt = {f3, 1'b1};
        case (f3)
          3'b000, 3'b001, 3'b010: ill = 1'b0;
          3'b011:                 ill = !RV64;
          default:                ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
        d.src_sel = SEL_RS1_IMM;
        d.exu_opt = alu_op(f3, (f3 == 3'b101) & ins_i[30]);
        wen = 1'b1;
        // RV64 shamt is 6 bits, so bit 25 belongs to the shift amount there.
        if (f3 == 3'b001)
          ill = RV64 ? (ins_i[31:26] != 6'b0) : (f7 != 7'b0);
        else if (f3 == 3'b101)
          ill = RV64 ? !(ins_i[31:26] inside {6'b000000, 6'b010000})
                     : !(f7 inside {7'b0000000, 7'b0100000});
      end
      OPC_OP: begin
        wen = 1'b1;
        if (f7 == 7'b0000000)
          d.exu_opt = alu_op(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          d.exu_opt = alu_op(f3, 1'b1);
        else if (f7 == 7'b0000001 && HAS_M)
          d.exu_opt = exu_opt_e'(EXU_OPT_WIDTH'(EXU_MUL) + EXU_OPT_WIDTH'(f3));
        else
          ill = 1'b1;
      end
      OPC_OP_IMM_32: begin
        imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
        d.src_sel = SEL_RS1_IMM;
        d.word = 1'b1;
        d.exu_opt = alu_op(f3, (f3 == 3'b101) & ins_i[30]);
        wen = 1'b1;
        case (f3)
          3'b000:  ill = !RV64;
          3'b001:  ill = !RV64 || (f7 != 7'b0);
          3'b101:  ill = !RV64 || !(f7 inside {7'b0000000, 7'b0100000});
          default: ill = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        d.word = 1'b1;
        wen = 1'b1;
        if (f7 == 7'b0000000 && (f3 inside {3'b000, 3'b001, 3'b101}))
          d.exu_opt = alu_op(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 inside {3'b000, 3'b101}))
          d.exu_opt = alu_op(f3, 1'b1);
        else if (f7 == 7'b0000001 && HAS_M && (f3 inside {3'b000, 3'b100, 3'b101, 3'b110, 3'b111}))
          d.exu_opt = exu_opt_e'(EXU_OPT_WIDTH'(EXU_MUL) + EXU_OPT_WIDTH'(f3));
        else
          ill = 1'b1;
        if (!RV64) ill = 1'b1;
      end
      OPC_SYSTEM: begin
        if (ins_i == INS_EBREAK) d.ebreak = 1'b1;
        else                     ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // A failed decode must not touch architectural state or redirect flow.
    if (ill) begin
      wen       = 1'b0;
      d.brch    = 1'b0;
      d.jal     = 1'b0;
      d.jalr    = 1'b0;
      d.word    = 1'b0;
      d.lsu_opt = LSU_NOP;
    end
    d.illegal = ill;
    d.rdwen   = wen && (d.rd != 5'd0);
  end

  assign dec_o = d;
  assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/idu_stage.sv
// Decode stage: single-entry output register with valid/ready handshake and a
// HALT state entered when an ebreak or illegal instruction leaves the stage.
module idu_stage
  import idu_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int EN_M = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_ins,
  input  logic [XLEN-1:0]          i_pc,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [XLEN-1:0]          o_pc,
  output logic [4:0]               o_rs1id,
  output logic [4:0]               o_rs2id,
  output logic [4:0]               o_rdid,
  output logic                     o_rdwen,
  output logic [XLEN-1:0]          o_imm,
  output logic [EXU_SEL_WIDTH-1:0] o_exu_src_sel,
  output logic [EXU_OPT_WIDTH-1:0] o_exu_opt,
  output logic [LSU_OPT_WIDTH-1:0] o_lsu_opt,
  output logic                     o_word,
  output logic                     o_brch,
  output logic                     o_jal,
  output logic                     o_jalr,
  output logic                     o_ebreak,
  output logic                     o_illegal
);

  state_e          state_q, state_d;
  dec_t            dec, dec_q;
  logic [XLEN-1:0] imm, imm_q, pc_q;
  logic            accept, load;

  idu_dec #(.XLEN(XLEN), .EN_M(EN_M)) u_dec (
    .ins_i (i_ins),
    .dec_o (dec),
    .imm_o (imm)
  );

  // An instruction accepted in the same cycle a trapping one leaves is dropped;
  // the HALT is always followed by a flush that would discard it anyway.
  always_comb begin
    state_d = state_q;
    o_ready = (state_q == ST_EMPTY) || (state_q == ST_FULL && i_ready);
    accept  = i_valid && o_ready;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL: begin
        if (i_ready) begin
          if (dec_q.ebreak || dec_q.illegal) state_d = ST_HALT;
          else if (accept)                   state_d = ST_FULL;
          else                               state_d = ST_EMPTY;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_EMPTY;
    endcase
    if (i_flush) state_d = ST_EMPTY;
    load = accept && (state_d == ST_FULL);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q         <= ST_EMPTY;
      dec_q           <= '0;
      dec_q.lsu_opt   <= LSU_NOP;
      imm_q           <= '0;
      pc_q            <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        dec_q <= dec;
        imm_q <= imm;
        pc_q  <= i_pc;
      end
    end
  end

  assign o_valid       = (state_q == ST_FULL);
  assign o_pc          = pc_q;
  assign o_rs1id       = dec_q.rs1;
  assign o_rs2id       = dec_q.rs2;
  assign o_rdid        = dec_q.rd;
  assign o_rdwen       = dec_q.rdwen;
  assign o_imm         = imm_q;
  assign o_exu_src_sel = dec_q.src_sel;
  assign o_exu_opt     = dec_q.exu_opt;
  assign o_lsu_opt     = dec_q.lsu_opt;
  assign o_word        = dec_q.word;
  assign o_brch        = dec_q.brch;
  assign o_jal         = dec_q.jal;
  assign o_jalr        = dec_q.jalr;
  assign o_ebreak      = dec_q.ebreak;
  assign o_illegal     = dec_q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Directed bench: an RV32+M stage (a_*) and an RV64 without M stage (b_*)
// share one input stream; expected values are hand-encoded per step.
module tb_idu_stage;
  import idu_stage_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, i_ready;
  logic [31:0] i_ins, i_pc;
  logic [63:0] pc64;

  logic        a_ready, a_valid, a_rdwen, a_word, a_brch, a_jal, a_jalr, a_ebreak, a_illegal;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [EXU_SEL_WIDTH-1:0] a_sel;
  logic [EXU_OPT_WIDTH-1:0] a_exu;
  logic [LSU_OPT_WIDTH-1:0] a_lsu;

  logic        b_ready, b_valid, b_rdwen, b_word, b_brch, b_jal, b_jalr, b_ebreak, b_illegal;
  logic [63:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [EXU_SEL_WIDTH-1:0] b_sel;
  logic [EXU_OPT_WIDTH-1:0] b_exu;
  logic [LSU_OPT_WIDTH-1:0] b_lsu;

  int checks = 0;
  int failures = 0;
  int xfer = 0;

  always #5 i_clk = ~i_clk;

  idu_stage #(.XLEN(32), .EN_M(1)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(a_ready), .i_ins(i_ins), .i_pc(i_pc), .o_valid(a_valid), .i_ready(i_ready),
    .o_pc(a_pc), .o_rs1id(a_rs1), .o_rs2id(a_rs2), .o_rdid(a_rd), .o_rdwen(a_rdwen),
    .o_imm(a_imm), .o_exu_src_sel(a_sel), .o_exu_opt(a_exu), .o_lsu_opt(a_lsu),
    .o_word(a_word), .o_brch(a_brch), .o_jal(a_jal), .o_jalr(a_jalr),
    .o_ebreak(a_ebreak), .o_illegal(a_illegal)
  );

  idu_stage #(.XLEN(64), .EN_M(0)) u_dut64 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid),
    .o_ready(b_ready), .i_ins(i_ins), .i_pc(pc64), .o_valid(b_valid), .i_ready(i_ready),
    .o_pc(b_pc), .o_rs1id(b_rs1), .o_rs2id(b_rs2), .o_rdid(b_rd), .o_rdwen(b_rdwen),
    .o_imm(b_imm), .o_exu_src_sel(b_sel), .o_exu_opt(b_exu), .o_lsu_opt(b_lsu),
    .o_word(b_word), .o_brch(b_brch), .o_jal(b_jal), .o_jalr(b_jalr),
    .o_ebreak(b_ebreak), .o_illegal(b_illegal)
  );

  always @(posedge i_clk) if (a_valid && i_ready) xfer <= xfer + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] pc, input logic rdy);
    i_valid = 1'b1;
    i_ins   = ins;
    i_pc    = pc[31:0];
    pc64    = pc;
    i_ready = rdy;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic flush_pulse(input string tag);
    i_valid = 1'b0;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk({tag, "_a_valid"}, a_valid, 0);
    chk({tag, "_a_ready"}, a_ready, 1);
    chk({tag, "_b_valid"}, b_valid, 0);
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b1; i_ready = 1'b0;
    i_ins = 32'hfff00093; i_pc = 32'h100; pc64 = 64'h100;
    tick(); tick();
    chk("rst_valid", a_valid, 0);
    chk("rst_ready", a_ready, 1);
    chk("rst_pc", a_pc, 0);
    chk("rst_imm", a_imm, 0);
    chk("rst_rdwen", a_rdwen, 0);
    chk("rst_rdid", a_rd, 0);
    chk("rst_illegal", a_illegal, 0);
    chk("rst_ebreak", a_ebreak, 0);
    chk("rst_lsu", a_lsu, 4'hf);
    chk("rst_b_imm", b_imm, 0);

    // addi x1,x0,-1 accepted on the first cycle out of reset
    i_rst_n = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("addi_valid", a_valid, 1);
    chk("addi_imm", a_imm, 32'hffffffff);
    chk("addi_rd", a_rd, 1);
    chk("addi_rdwen", a_rdwen, 1);
    chk("addi_exu", a_exu, EXU_ADD);
    chk("addi_sel", a_sel, SEL_RS1_IMM);
    chk("addi_pc", a_pc, 32'h100);
    chk("addi_b_imm", b_imm, 64'hffffffffffffffff);

    // backpressure with add x5,x6,x7 waiting upstream
    i_valid = 1'b1; i_ins = 32'h007302b3; i_pc = 32'h104; pc64 = 64'h104;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ready", a_ready, 0);
      chk("bp_valid", a_valid, 1);
      chk("bp_pc", a_pc, 32'h100);
      chk("bp_imm", a_imm, 32'hffffffff);
    end
    i_ready = 1'b1;
    #1;
    chk("bp_release_ready", a_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("add_pc", a_pc, 32'h104);
    chk("add_rd", a_rd, 5);
    chk("add_rs1", a_rs1, 6);
    chk("add_rs2", a_rs2, 7);
    chk("add_sel", a_sel, SEL_RS1_RS2);
    chk("add_valid", a_valid, 1);
    tick();
    chk("drain_valid", a_valid, 0);
    chk("xfer_count", xfer, 2);

    send(32'hfe732e23, 64'h108, 1'b1);     // sw x7,-4(x6)
    chk("sw_lsu", a_lsu, 4'b0101);
    chk("sw_imm", a_imm, 32'hfffffffc);
    chk("sw_rdwen", a_rdwen, 0);
    send(32'hfe208ce3, 64'h10c, 1'b1);     // beq x1,x2,-8
    chk("beq_brch", a_brch, 1);
    chk("beq_imm", a_imm, 32'hfffffff8);
    chk("beq_exu", a_exu, EXU_BEQ);
    chk("beq_rdwen", a_rdwen, 0);
    send(32'h80000537, 64'h110, 1'b1);     // lui x10,0x80000
    chk("lui_imm", a_imm, 32'h80000000);
    chk("lui_b_imm", b_imm, 64'hffffffff80000000);
    chk("lui_rdwen", a_rdwen, 1);
    chk("lui_sel", a_sel, SEL_ZERO_IMM);
    send(32'h001000ef, 64'h114, 1'b1);     // jal x1,+2048
    chk("jal_jal", a_jal, 1);
    chk("jal_imm", a_imm, 32'h800);
    chk("jal_rdwen", a_rdwen, 1);
    send(32'h00008067, 64'h118, 1'b1);     // jalr x0,0(x1)
    chk("jalr_jalr", a_jalr, 1);
    chk("jalr_rdwen", a_rdwen, 0);
    chk("jalr_illegal", a_illegal, 0);

    send(32'h0010811b, 64'h11c, 1'b1);     // addiw x2,x1,1
    chk("addiw_b_word", b_word, 1);
    chk("addiw_b_illegal", b_illegal, 0);
    chk("addiw_b_imm", b_imm, 64'h1);
    chk("addiw_b_rdwen", b_rdwen, 1);
    chk("addiw_a_illegal", a_illegal, 1);
    chk("addiw_a_word", a_word, 0);
    chk("addiw_a_rdwen", a_rdwen, 0);
    flush_pulse("fl1");
    send(32'h0080b183, 64'h120, 1'b1);     // ld x3,8(x1)
    chk("ld_b_lsu", b_lsu, 4'b0110);
    chk("ld_b_illegal", b_illegal, 0);
    chk("ld_b_rdwen", b_rdwen, 1);
    chk("ld_a_illegal", a_illegal, 1);
    chk("ld_a_lsu", a_lsu, 4'hf);
    flush_pulse("fl2");
    send(32'h022081b3, 64'h124, 1'b1);     // mul x3,x1,x2
    chk("mul_exu", a_exu, EXU_MUL);
    chk("mul_illegal", a_illegal, 0);
    chk("mul_rdwen", a_rdwen, 1);
    chk("mul_b_illegal", b_illegal, 1);
    chk("mul_b_rdwen", b_rdwen, 0);
    flush_pulse("fl3");

    // illegal word held, then leaves -> HALT until flush
    send(32'hffffffff, 64'h128, 1'b0);
    chk("ill_illegal", a_illegal, 1);
    chk("ill_rdwen", a_rdwen, 0);
    chk("ill_brch", a_brch, 0);
    chk("ill_jal", a_jal, 0);
    chk("ill_jalr", a_jalr, 0);
    chk("ill_lsu", a_lsu, 4'hf);
    chk("ill_ready", a_ready, 0);
    i_ready = 1'b1;
    tick();
    chk("halt_valid", a_valid, 0);
    chk("halt_ready", a_ready, 0);
    i_valid = 1'b1; i_ins = 32'hfff00093;
    tick();
    chk("halt_hold_ready", a_ready, 0);
    chk("halt_hold_valid", a_valid, 0);
    flush_pulse("fl4");
    send(32'h00100073, 64'h12c, 1'b0);     // ebreak
    chk("ebrk_ebreak", a_ebreak, 1);
    chk("ebrk_illegal", a_illegal, 0);
    chk("ebrk_rdwen", a_rdwen, 0);
    i_ready = 1'b1;
    tick();
    chk("ebrk_halt_ready", a_ready, 0);
    chk("ebrk_halt_valid", a_valid, 0);
    flush_pulse("fl5");

    // flush and valid together while FULL: nothing captured
    send(32'hfff00093, 64'h200, 1'b0);
    chk("fv_full", a_valid, 1);
    i_valid = 1'b1; i_ins = 32'h007302b3; i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("fv_valid0", a_valid, 0);
    tick();
    chk("fv_valid1", a_valid, 0);

    // reset while FULL
    send(32'h80000537, 64'h300, 1'b0);
    chk("rf_full", a_valid, 1);
    i_rst_n = 1'b0;
    tick();
    chk("rf_valid", a_valid, 0);
    chk("rf_imm", a_imm, 0);
    chk("rf_pc", a_pc, 0);
    chk("rf_rdwen", a_rdwen, 0);
    chk("rf_rd", a_rd, 0);
    chk("rf_lsu", a_lsu, 4'hf);
    chk("rf_ready", a_ready, 1);
    i_rst_n = 1'b1;
    tick();
    chk("rf_after_valid", a_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
